adsr_env: RTL

Parametrised attack-decay-sustain-release envelope generator and amplitude scaler. It sits between the note oscillator and the audio output path. It advances a 5-state envelope once per incoming sample strobe, driven by a gate and runtime-programmable rates and sustain level. It multiplies each signed input sample by the current envelope level. It adds retrigger-from-release, instant (zero-step) segments and live sustain tracking.

---
 rtl/adsr_env.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/adsr_env.sv
// adsr_env: attack-decay-sustain-release envelope generator with amplitude scaling.
// The envelope advances once per sample strobe (in_ready). Each strobed sample is
// multiplied by the envelope level held before that strobe's update.
// Ports:
//   clk, reset           - rising-edge clock, asynchronous active-high reset
//   in_ready, sample_in  - sample strobe and signed input sample
//   gate                 - note held, sampled on strobes only
//   attack/decay/release_step, sustain_level - runtime envelope programming
//   sample_out, out_valid - scaled sample and its one-cycle valid pulse
//   env_level, env_state, active - envelope observation
module adsr_env #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned ENV_W    = 16,
  parameter int unsigned RATE_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_ready,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       gate,
  input  logic        [RATE_W-1:0]   attack_step,
  input  logic        [RATE_W-1:0]   decay_step,
  input  logic        [ENV_W-1:0]    sustain_level,
  input  logic        [RATE_W-1:0]   release_step,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       out_valid,
  output logic        [ENV_W-1:0]    env_level,
  output logic        [2:0]          env_state,
  output logic                       active
);

  localparam int unsigned EXT_W  = ENV_W + 1;
  localparam int unsigned PROD_W = SAMPLE_W + ENV_W + 1;
  localparam logic [ENV_W-1:0] ENV_MAX = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t            state;
  logic [ENV_W-1:0]  level;

  logic [EXT_W-1:0]  att_sum;
  logic [EXT_W-1:0]  dec_diff;
  logic [EXT_W-1:0]  rel_diff;
  logic [ENV_W-1:0]  att_next;
  logic [ENV_W-1:0]  dec_next;
  logic [ENV_W-1:0]  rel_next;

  logic signed [PROD_W-1:0]   samp_ext;
  logic signed [PROD_W-1:0]   lvl_ext;
  logic signed [PROD_W-1:0]   prod;
  logic signed [SAMPLE_W-1:0] scaled;
  logic                       unused_prod_bits;

  // Segment arithmetic on one extra bit so saturation/underflow is detectable.
  always_comb begin
    att_sum  = {1'b0, level} + EXT_W'(attack_step);
    dec_diff = {1'b0, level} - EXT_W'(decay_step);
    rel_diff = {1'b0, level} - EXT_W'(release_step);

    att_next = att_sum[ENV_W-1:0];
    if (attack_step == '0 || att_sum[ENV_W]) att_next = ENV_MAX;

    // Decay never lands below sustain, and snaps up if sustain was raised.
    dec_next = dec_diff[ENV_W-1:0];
    if (decay_step == '0 || level <= sustain_level || dec_diff[ENV_W] ||
        dec_diff[ENV_W-1:0] <= sustain_level)
      dec_next = sustain_level;

    rel_next = rel_diff[ENV_W-1:0];
    if (release_step == '0 || rel_diff[ENV_W]) rel_next = '0;
  end

  // Signed sample times non-negative level; floor shift then truncate.
  always_comb begin
    samp_ext = PROD_W'(sample_in);
    lvl_ext  = PROD_W'($signed({1'b0, level}));
    prod     = samp_ext * lvl_ext;
    scaled   = prod[ENV_W +: SAMPLE_W];
  end

  assign unused_prod_bits = ^{prod[PROD_W-1:ENV_W+SAMPLE_W], prod[ENV_W-1:0]};

  // Envelope FSM, level register and scaled output; all updates gated by in_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      level      <= '0;
      sample_out <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= in_ready;
      if (in_ready) begin
        sample_out <= scaled;
        unique case (state)
          IDLE: begin
            level <= '0;
            if (gate) state <= ATTACK;
          end
          ATTACK: begin
            if (!gate) begin
              state <= RELEASE;
            end else begin
              level <= att_next;
              if (att_next == ENV_MAX) state <= DECAY;
            end
          end
          DECAY: begin
            if (!gate) begin
              state <= RELEASE;
            end else begin
              level <= dec_next;
              if (dec_next == sustain_level) state <= SUSTAIN;
            end
          end
          SUSTAIN: begin
            if (!gate) state <= RELEASE;
            else       level <= sustain_level;
          end
          RELEASE: begin
            // Retrigger keeps the current level as the attack start point.
            if (gate) begin
              state <= ATTACK;
            end else begin
              level <= rel_next;
              if (rel_next == '0) state <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
            level <= '0;
          end
        endcase
      end
    end
  end

  assign env_level = level;
  assign env_state = state;
  assign active    = (state != IDLE);

endmodule
